game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/breakout_pkg.sv | 20 ++
 rtl/edge_det.sv | 24 ++
 rtl/game_fsm.sv | 121 ++++++++++++
 tb/tb_game_fsm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared state codes, default parameters and helpers for the breakout game FSM
package breakout_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_MISS  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  localparam int DEF_LIVES          = 3;
  localparam int DEF_SERVE_FRAMES   = 60;
  localparam int DEF_HITS_PER_LEVEL = 8;
  localparam int DEF_MAX_SPEED      = 4;

  function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] limit);
    return (value < limit) ? value + 3'd1 : value;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered edge detector; pulse is the input against its registered copy
module edge_det #(
  parameter logic RESET_VAL = 1'b0,
  parameter logic FALLING   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic edge_pulse
);

  logic d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign edge_pulse = FALLING ? (d_q & ~d) : (d & ~d_q);

endmodule

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - breakout game sequencer: frame timing, serve countdown, lives and speed
module game_fsm
  import breakout_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int MAX_SPEED      = DEF_MAX_SPEED
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vga_vs,
  input  logic       start,
  input  logic       pause,
  input  logic       hit_bar,
  input  logic       ball_lost,
  output logic       frame_tick,
  output logic       step,
  output logic       serve,
  output logic [1:0] lives,
  output logic [2:0] speed,
  output logic [2:0] state,
  output logic       game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_INIT = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
  localparam logic [2:0] SPEED_MAX  = 3'(MAX_SPEED);

  logic       vs_fall;
  logic       start_rise;
  logic [7:0] serve_cnt;
  logic [3:0] hit_cnt;

  edge_det #(.RESET_VAL(1'b1), .FALLING(1'b1)) u_vs_edge (
    .clock      (clock),
    .reset      (reset),
    .d          (vga_vs),
    .edge_pulse (vs_fall)
  );

  // Start register resets high so a start held through reset is not an edge.
  edge_det #(.RESET_VAL(1'b1), .FALLING(1'b0)) u_start_edge (
    .clock      (clock),
    .reset      (reset),
    .d          (start),
    .edge_pulse (start_rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      lives      <= LIVES_INIT;
      speed      <= 3'd1;
      hit_cnt    <= 4'd0;
      serve_cnt  <= 8'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= vs_fall;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            lives     <= LIVES_INIT;
            speed     <= 3'd1;
            hit_cnt   <= 4'd0;
            serve_cnt <= SERVE_INIT;
            state     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == 8'd0) begin
              state <= ST_PLAY;
            end else begin
              serve_cnt <= serve_cnt - 8'd1;
            end
          end
        end
        ST_PLAY: begin
          // A loss in the same cycle as a hit or pause wins outright.
          if (ball_lost) begin
            lives <= lives - 2'd1;
            state <= ST_MISS;
          end else begin
            if (hit_bar) begin
              if (hit_cnt == HIT_LAST) begin
                hit_cnt <= 4'd0;
                speed   <= sat_inc(speed, SPEED_MAX);
              end else begin
                hit_cnt <= hit_cnt + 4'd1;
              end
            end
            if (pause) begin
              state <= ST_PAUSE;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state <= ST_PLAY;
          end
        end
        ST_MISS: begin
          if (lives == 2'd0) begin
            state <= ST_OVER;
          end else begin
            serve_cnt <= SERVE_INIT;
            state     <= ST_SERVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign step      = frame_tick & (state == ST_PLAY) & ~reset;
  assign serve     = reset | (state == ST_IDLE) | (state == ST_SERVE) | (state == ST_MISS);
  assign game_over = ~reset & (state == ST_OVER);

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - directed self-checking bench for game_fsm
module tb_game_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vga_vs = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       hit_bar = 1'b0;
  logic       ball_lost = 1'b0;
  logic       frame_tick;
  logic       step;
  logic       serve;
  logic [1:0] lives;
  logic [2:0] speed;
  logic [2:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int steps_seen;

  game_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .vga_vs     (vga_vs),
    .start      (start),
    .pause      (pause),
    .hit_bar    (hit_bar),
    .ball_lost  (ball_lost),
    .frame_tick (frame_tick),
    .step       (step),
    .serve      (serve),
    .lives      (lives),
    .speed      (speed),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One frame: falling vs edge, the frame_tick cycle, then vs back high.
  task automatic frame(input logic lost);
    vga_vs = 1'b0;
    cyc();
    if (step) steps_seen++;
    ball_lost = lost;
    cyc();
    ball_lost = 1'b0;
    vga_vs = 1'b1;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit_bar = 1'b1;
      cyc();
      hit_bar = 1'b0;
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (state !== 3'd0 || lives !== 2'd3 || speed !== 3'd1) begin
      errors++;
      $display("FAIL reset_regs: state=%0d lives=%0d speed=%0d, want 0 3 1", state, lives, speed);
    end
    checks++;
    if (serve !== 1'b1 || step !== 1'b0 || game_over !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: serve=%b step=%b go=%b ft=%b, want 1 0 0 0", serve, step, game_over, frame_tick);
    end
  endtask

  task automatic test_start_held();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL start_held: state=%0d, want 0", state);
    end
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    checks++;
    if (state !== 3'd1 || lives !== 2'd3) begin
      errors++;
      $display("FAIL start_edge: state=%0d lives=%0d, want 1 3", state, lives);
    end
    start = 1'b0;
  endtask

  task automatic test_serve();
    steps_seen = 0;
    frames(59);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL serve_59: state=%0d, want 1", state);
    end
    frames(1);
    checks++;
    if (state !== 3'd2 || steps_seen !== 0) begin
      errors++;
      $display("FAIL serve_60: state=%0d steps=%0d, want 2 0", state, steps_seen);
    end
    frames(1);
    checks++;
    if (steps_seen !== 1) begin
      errors++;
      $display("FAIL step_61: steps=%0d, want 1", steps_seen);
    end
  endtask

  task automatic test_lost_with_hit();
    hits(7);
    checks++;
    if (speed !== 3'd1) begin
      errors++;
      $display("FAIL hits_7: speed=%0d, want 1", speed);
    end
    ball_lost = 1'b1;
    hit_bar = 1'b1;
    cyc();
    ball_lost = 1'b0;
    hit_bar = 1'b0;
    checks++;
    if (state !== 3'd4 || lives !== 2'd2 || speed !== 3'd1) begin
      errors++;
      $display("FAIL lost_hit_miss: state=%0d lives=%0d speed=%0d, want 4 2 1", state, lives, speed);
    end
    cyc();
    checks++;
    if (state !== 3'd1 || serve !== 1'b1) begin
      errors++;
      $display("FAIL miss_to_serve: state=%0d serve=%b, want 1 1", state, serve);
    end
    frames(60);
    hits(1);
    checks++;
    if (state !== 3'd2 || speed !== 3'd2) begin
      errors++;
      $display("FAIL hits_8: state=%0d speed=%0d, want 2 2", state, speed);
    end
  endtask

  task automatic test_speed();
    hits(24);
    checks++;
    if (speed !== 3'd4) begin
      errors++;
      $display("FAIL hits_32: speed=%0d, want 4", speed);
    end
    hits(8);
    checks++;
    if (speed !== 3'd4) begin
      errors++;
      $display("FAIL hits_40: speed=%0d, want 4", speed);
    end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    cyc();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL pause_enter: state=%0d, want 3", state);
    end
    steps_seen = 0;
    for (int i = 0; i < 10; i++) frame(1'b1);
    checks++;
    if (state !== 3'd3 || steps_seen !== 0 || lives !== 2'd2) begin
      errors++;
      $display("FAIL pause_hold: state=%0d steps=%0d lives=%0d, want 3 0 2", state, steps_seen, lives);
    end
    pause = 1'b0;
    cyc();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL pause_exit: state=%0d, want 2", state);
    end
  endtask

  task automatic test_game_over();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (state !== 3'd2 || lives !== 2'd2) begin
      errors++;
      $display("FAIL start_in_play: state=%0d lives=%0d, want 2 2", state, lives);
    end
    ball_lost = 1'b1;
    cyc();
    ball_lost = 1'b0;
    cyc();
    frames(60);
    ball_lost = 1'b1;
    cyc();
    ball_lost = 1'b0;
    checks++;
    if (state !== 3'd4 || lives !== 2'd0) begin
      errors++;
      $display("FAIL last_miss: state=%0d lives=%0d, want 4 0", state, lives);
    end
    cyc();
    checks++;
    if (state !== 3'd5 || game_over !== 1'b1 || serve !== 1'b0) begin
      errors++;
      $display("FAIL over: state=%0d go=%b serve=%b, want 5 1 0", state, game_over, serve);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || lives !== 2'd3 || speed !== 3'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d lives=%0d speed=%0d go=%b, want 1 3 1 0", state, lives, speed, game_over);
    end
  endtask

  task automatic test_reset_mid();
    frames(30);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || lives !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_serve: state=%0d lives=%0d, want 0 3", state, lives);
    end
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    frames(60);
    vga_vs = 1'b0;
    cyc();
    checks++;
    if (step !== 1'b1) begin
      errors++;
      $display("FAIL step_before_reset: step=%b, want 1", step);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (step !== 1'b0 || serve !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb: step=%b serve=%b, want 0 1", step, serve);
    end
    cyc();
    checks++;
    if (state !== 3'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_play: state=%0d ft=%b, want 0 0", state, frame_tick);
    end
    reset = 1'b0;
    vga_vs = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_serve();
    test_lost_with_hit();
    test_speed();
    test_pause();
    test_game_over();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
